// File: rtl/hdb3_dac_shaper_if.sv
// Bundle of strobe, P/N rails, mode selects and DAC-side outputs for hdb3_dac_shaper.
// master drives the line-code side, slave is the shaper.
interface hdb3_dac_shaper_if #(parameter int DW = 8);
  logic          sym_stb;
  logic          data_inP;
  logic          data_inN;
  logic          rz_en;
  logic          slew_en;
  logic [DW-1:0] data_out;
  logic          err;
  logic [15:0]   err_cnt;
  logic          los;

  modport master (output sym_stb, data_inP, data_inN, rz_en, slew_en,
                  input  data_out, err, err_cnt, los);
  modport slave  (input  sym_stb, data_inP, data_inN, rz_en, slew_en,
                  output data_out, err, err_cnt, los);
endinterface

// File: rtl/hdb3_dac_shaper.sv
// HDB3 P/N rail pair to DW-bit DAC code: NRZ or 50% RZ shaping, optional slew
// limit, illegal-code counting and loss-of-signal fallback to mid-scale.
module hdb3_dac_shaper #(
  parameter int DW      = 8,
  parameter int OSR     = 8,
  parameter int STEP    = 32,
  parameter int LOS_SYM = 4
) (
  input logic              clk,
  input logic              rst,
  hdb3_dac_shaper_if.slave io
);
  localparam int WD_MAX = LOS_SYM * OSR;
  localparam int WDW    = $clog2(WD_MAX + 1);
  localparam int PHW    = $clog2(OSR);

  localparam logic [DW-1:0]  MID     = {1'b1, {(DW-1){1'b0}}};
  localparam logic [DW-1:0]  STEP_D  = DW'(STEP);
  localparam logic [PHW-1:0] PH_MAX  = PHW'(OSR - 1);
  localparam logic [PHW-1:0] PH_HALF = PHW'(OSR / 2);
  localparam logic [WDW-1:0] WD_TOP  = WDW'(WD_MAX);
  localparam logic [WDW-1:0] WD_EXP  = WDW'(WD_MAX - 1);

  logic [DW-1:0]  level, dec, lvl_eff, d, slew, out_q, out_nxt;
  logic [DW:0]    up, dn;
  logic [PHW-1:0] ph, ph_nxt;
  logic [WDW-1:0] wd;
  logic [15:0]    cnt;
  logic           illegal, err_q, los_q;

  // A strobe's symbol drives the output in the very next cycle, so the
  // desired code is built from the decoded (not yet registered) level.
  always_comb begin
    illegal = io.data_inP & io.data_inN;
    case ({io.data_inP, io.data_inN})
      2'b10:   dec = '1;
      2'b01:   dec = '0;
      2'b00:   dec = MID;
      default: dec = level;
    endcase
    lvl_eff = io.sym_stb ? dec : level;
    ph_nxt  = io.sym_stb ? '0 : ((ph == PH_MAX) ? ph : ph + PHW'(1));
    d       = (io.rz_en && ph_nxt >= PH_HALF) ? MID : lvl_eff;

    // Differences in DW+1 bits: the top bit flags "wrong direction".
    up = {1'b0, d} - {1'b0, out_q};
    dn = {1'b0, out_q} - {1'b0, d};
    if (!up[DW] && up > {1'b0, STEP_D})      slew = out_q + STEP_D;
    else if (!dn[DW] && dn > {1'b0, STEP_D}) slew = out_q - STEP_D;
    else                                     slew = d;
    out_nxt = io.slew_en ? slew : d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level <= MID;
      out_q <= MID;
      ph    <= PH_MAX;
      wd    <= '0;
      err_q <= 1'b0;
      cnt   <= '0;
      los_q <= 1'b0;
    end else begin
      out_q <= out_nxt;
      ph    <= ph_nxt;
      err_q <= io.sym_stb & illegal;
      if (io.sym_stb) begin
        // wd holds cycles elapsed since the strobe as seen in the current cycle
        level <= dec;
        wd    <= WDW'(1);
        los_q <= 1'b0;
        if (illegal && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
      end else begin
        if (wd != WD_TOP) wd <= wd + WDW'(1);
        if (wd == WD_EXP) begin
          los_q <= 1'b1;
          level <= MID;
        end
      end
    end
  end

  assign io.data_out = out_q;
  assign io.err      = err_q;
  assign io.err_cnt  = cnt;
  assign io.los      = los_q;
endmodule

// File: tb/tb_hdb3_dac_shaper.sv
// Scoreboard bench: a time-based reference model predicts every output cycle,
// a monitor process pops and compares after each rising edge.
module tb_hdb3_dac_shaper;
  localparam int DW = 8, OSR = 8, STEP = 32, LOS_SYM = 4;
  localparam int LOS_N = LOS_SYM * OSR;
  localparam int MID = 1 << (DW - 1);
  localparam int HI = (1 << DW) - 1;

  typedef struct {
    int          cyc;
    int          d;
    bit          e;
    int          c;
    bit          l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  hdb3_dac_shaper_if #(.DW(DW)) io ();

  hdb3_dac_shaper #(.DW(DW), .OSR(OSR), .STEP(STEP), .LOS_SYM(LOS_SYM)) dut (
    .clk(clk), .rst(rst), .io(io)
  );

  always #5 clk = ~clk;

  exp_t q[$];
  int total = 0, bad = 0;

  // reference model state, expressed as absolute cycle numbers
  int cyc = 0;
  int t_last, wd_org;
  int m_lvl = MID, m_out = MID, m_cnt = 0;
  bit m_err = 0, m_los = 0;
  bit rz = 0, sl = 0;

  task automatic step(input bit r, input bit s, input bit p, input bit n);
    exp_t e;
    int   dsr;
    bit   expire;
    rst = r; io.sym_stb = s; io.data_inP = p; io.data_inN = n;
    io.rz_en = rz; io.slew_en = sl;
    expire = 0;
    if (r) begin
      m_lvl = MID; m_out = MID; m_err = 0; m_cnt = 0; m_los = 0;
      t_last = cyc - OSR; wd_org = cyc + 1;
    end else begin
      if (s) begin
        if (p && !n) m_lvl = HI;
        else if (!p && n) m_lvl = 0;
        else if (!p && !n) m_lvl = MID;
        t_last = cyc; wd_org = cyc;
        m_err = p & n;
        if (p && n && m_cnt < 65535) m_cnt++;
        m_los = 0;
      end else begin
        m_err = 0;
        expire = (cyc + 1 - wd_org == LOS_N);
      end
      dsr = (rz && (cyc - t_last) >= OSR / 2) ? MID : m_lvl;
      if (!sl) m_out = dsr;
      else if (dsr > m_out) m_out = (m_out + STEP < dsr) ? m_out + STEP : dsr;
      else m_out = (m_out - STEP > dsr) ? m_out - STEP : dsr;
      if (expire) begin m_los = 1; m_lvl = MID; end
    end
    e.cyc = cyc + 1; e.d = m_out; e.e = m_err; e.c = m_cnt; e.l = m_los;
    q.push_back(e);
    cyc++;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0);
  endtask

  task automatic sym(input bit p, input bit n, input int gap);
    step(0, 1, p, n);
    idle(gap - 1);
  endtask

  // monitor: one expected entry per cycle after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        total++;
        if (io.data_out !== DW'(e.d)) begin
          bad++; $display("FAIL data_out cyc=%0d got=%0h exp=%0h", e.cyc, io.data_out, e.d);
        end
        total++;
        if (io.err !== e.e) begin
          bad++; $display("FAIL err cyc=%0d got=%0b exp=%0b", e.cyc, io.err, e.e);
        end
        total++;
        if (io.err_cnt !== 16'(e.c)) begin
          bad++; $display("FAIL err_cnt cyc=%0d got=%0h exp=%0h", e.cyc, io.err_cnt, e.c);
        end
        total++;
        if (io.los !== e.l) begin
          bad++; $display("FAIL los cyc=%0d got=%0b exp=%0b", e.cyc, io.los, e.l);
        end
      end
    end
  end

  initial begin
    rst = 1; io.sym_stb = 0; io.data_inP = 0; io.data_inN = 0;
    io.rz_en = 0; io.slew_en = 0;
    step(1, 0, 0, 0); step(1, 0, 0, 0);
    idle(3);
    // NRZ levels
    sym(1, 0, 8); sym(0, 1, 8); sym(0, 0, 8);
    // RZ
    rz = 1; sym(1, 0, 8); sym(0, 1, 8); rz = 0;
    // illegal after a mark, plus closely spaced strobes
    sym(1, 0, 8); sym(1, 1, 3); sym(0, 1, 1); sym(1, 0, 5);
    // slew ramps
    sl = 1; sym(0, 0, 4); sym(0, 1, 9); sym(1, 0, 10); sl = 0;
    // loss of signal and recovery
    sym(1, 0, 40); sym(0, 1, 8);
    // loss of signal while slewing, with RZ
    sl = 1; rz = 1; sym(0, 1, 40); sym(1, 0, 8); sl = 0; rz = 0;
    // reset mid-ramp
    sl = 1; sym(0, 1, 3); step(1, 0, 0, 0); idle(4); sl = 0;

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      int r;
      r = int'($urandom_range(0, 999));
      if (r < 4) step(1, 0, 0, 0);
      else begin
        if ($urandom_range(0, 15) == 0) rz = ~rz;
        if ($urandom_range(0, 15) == 0) sl = ~sl;
        if ($urandom_range(0, 99) < 3)
          idle(int'($urandom_range(LOS_N - 2, LOS_N + 6)));
        else
          step(0, ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1);
      end
    end

    // counter saturation
    step(1, 0, 0, 0);
    for (int i = 0; i < 70000; i++) step(0, 1, 1, 1);
    total++;
    if (io.err_cnt !== 16'hFFFF) begin
      bad++; $display("FAIL err_cnt_sat got=%0h exp=ffff", io.err_cnt);
    end
    idle(3);
    #5;
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL drain got=%0d exp=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
